// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states, RV32I
// width codes, port ids and the request legality check.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } arb_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Port id doubles as the last-grant flag value; LS is 0 so reset clears it.
    localparam logic PORT_LS = 1'b0;
    localparam logic PORT_IF = 1'b1;

    function automatic logic req_illegal(input logic       is_ls,
                                         input logic       we,
                                         input logic [2:0] f3,
                                         input logic [1:0] a);
        logic bad_s;
        bad_s = 1'b0;
        if (!is_ls) begin
            bad_s = (a != 2'b00);
        end else begin
            case (f3)
                F3_B:    bad_s = 1'b0;
                F3_H:    bad_s = a[0];
                F3_W:    bad_s = (a != 2'b00);
                F3_BU:   bad_s = we;
                F3_HU:   bad_s = we | a[0];
                default: bad_s = 1'b1;
            endcase
        end
        return bad_s;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a sole requester wins, a tie goes to the
// index that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Grant decode from the request pair and the last-winner index
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load-store port onto one data
// memory: accept, one ACCESS cycle, then a one-cycle response strobe.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [2:0]        ls_funct3,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic              ls_err,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic              ls_err_q, ls_err_d;

    logic              can_accept_s;
    logic [1:0]        req_s;
    logic [1:0]        gnt_s;
    logic              accept_s;
    logic              access_s;
    logic              illegal_s;
    logic [DATA_W-1:0] rsp_data_s;

    // Grants are suppressed while reset is held so every output reads 0.
    assign can_accept_s = rst_n & ((state_q == ST_IDLE) | (state_q == ST_RESP));
    assign req_s        = {if_req, ls_req} & {2{can_accept_s}};
    assign accept_s     = |gnt_s;
    assign access_s     = (state_q == ST_ACCESS);
    assign illegal_s    = req_illegal(port_q == PORT_LS, we_q, f3_q, addr_q[1:0]);

    rr_arb2 u_rr_arb2 (
        .req  (req_s),
        .last (last_q),
        .gnt  (gnt_s)
    );

    assign if_gnt    = gnt_s[PORT_IF];
    assign ls_gnt    = gnt_s[PORT_LS];
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign ls_err    = ls_err_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = accept_s ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = accept_s ? ST_ACCESS : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request capture on accept; fetches are forced to a word read
    always_comb begin
        last_d  = last_q;
        port_d  = port_q;
        addr_d  = addr_q;
        we_d    = we_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        if (accept_s) begin
            last_d = gnt_s[PORT_IF] ? PORT_IF : PORT_LS;
            port_d = gnt_s[PORT_IF] ? PORT_IF : PORT_LS;
            if (gnt_s[PORT_IF]) begin
                addr_d  = if_addr;
                we_d    = 1'b0;
                f3_d    = F3_W;
                wdata_d = {DATA_W{1'b0}};
            end else begin
                addr_d  = ls_addr;
                we_d    = ls_we;
                f3_d    = ls_funct3;
                wdata_d = ls_wdata;
            end
        end else begin
            last_d = last_q;
        end
    end

    // Response capture at the end of ACCESS; data holds until the next response
    always_comb begin
        rsp_data_s  = (illegal_s | we_q) ? {DATA_W{1'b0}} : mem_rdata;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        ls_err_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if (access_s) begin
            if (port_q == PORT_IF) begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = rsp_data_s;
            end else begin
                ls_rvalid_d = 1'b1;
                ls_err_d    = illegal_s;
                ls_rdata_d  = rsp_data_s;
            end
        end else begin
            if_rvalid_d = 1'b0;
        end
    end

    // Memory-side drive, active only during ACCESS
    always_comb begin
        mem_addr   = {ADDR_W{1'b0}};
        mem_wdata  = {DATA_W{1'b0}};
        mem_funct3 = 3'b000;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        if (access_s) begin
            mem_addr   = addr_q;
            mem_wdata  = wdata_q;
            mem_funct3 = f3_q;
            mem_we     = we_q & ~illegal_s;
            mem_re     = ~we_q & ~illegal_s;
        end else begin
            mem_we     = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= PORT_LS;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            if_rdata_q  <= {DATA_W{1'b0}};
            ls_rdata_q  <= {DATA_W{1'b0}};
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            ls_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            port_q      <= port_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_err_q    <= ls_err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge and
// outputs are sampled one time unit later, well clear of the rising edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_rvalid, ls_err;
    logic [31:0] ls_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we, mem_re;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_funct3  (ls_funct3),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_err     (ls_err),
        .ls_rdata   (ls_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_funct3 (mem_funct3),
        .mem_rdata  (mem_rdata)
    );

    // Combinational memory: a fixed pattern per address, 0x13 at 0x100
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0000_0013;
        else return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    always_comb mem_rdata = mem_model(mem_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_funct3 = 3'b000; ls_addr = 32'h0; ls_wdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated load-store transaction starting from IDLE
    task automatic ls_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic exp_err);
        @(negedge clk);
        ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = a; ls_wdata = wd;
        #1;
        check("txn_gnt", ls_gnt, 1'b1);
        check("txn_if_gnt", if_gnt, 1'b0);
        @(negedge clk);
        ls_req = 1'b0;
        #1;
        check("txn_mem_re", mem_re, !exp_err && !we);
        check("txn_mem_we", mem_we, !exp_err && we);
        check("txn_early_rvalid", ls_rvalid, 1'b0);
        if (!exp_err) begin
            check("txn_mem_addr", mem_addr, a);
            check("txn_mem_f3", mem_funct3, f3);
        end
        if (!exp_err && we) check("txn_mem_wdata", mem_wdata, wd);
        @(negedge clk);
        #1;
        check("txn_rvalid", ls_rvalid, 1'b1);
        check("txn_err", ls_err, exp_err);
        check("txn_rdata", ls_rdata, (exp_err || we) ? 32'h0 : mem_model(a));
        check("txn_if_rvalid", if_rvalid, 1'b0);
        check("txn_mem_idle", {mem_re, mem_we}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_q[$];
        int gnts, rvs, last_g, cyc;

        // Reset state with requests already pending
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h0; ls_wdata = 32'h0;
        #3;
        check("rst_gnt", {if_gnt, ls_gnt}, 2'b00);
        check("rst_mem", {mem_re, mem_we}, 2'b00);
        check("rst_rvalid", {if_rvalid, ls_rvalid, ls_err}, 3'b000);
        check("rst_rdata", {if_rdata, ls_rdata}, 64'h0);
        do_reset();

        // Fetch only, granted on the first edge after release
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        check("f_gnt", if_gnt, 1'b1);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check("f_mem_re", mem_re, 1'b1);
        check("f_mem_addr", mem_addr, 32'h100);
        check("f_mem_f3", mem_funct3, 3'b010);
        check("f_early_rvalid", if_rvalid, 1'b0);
        @(negedge clk);
        #1;
        check("f_rvalid", if_rvalid, 1'b1);
        check("f_rdata", if_rdata, 32'h13);
        check("f_mem_re_off", mem_re, 1'b0);
        @(negedge clk);
        #1;
        check("f_rvalid_pulse", if_rvalid, 1'b0);
        check("f_rdata_hold", if_rdata, 32'h13);

        // Misaligned fetch: no memory access, no error, zero data
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h102;
        #1;
        check("fm_gnt", if_gnt, 1'b1);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check("fm_mem", {mem_re, mem_we}, 2'b00);
        @(negedge clk);
        #1;
        check("fm_rvalid", if_rvalid, 1'b1);
        check("fm_rdata", if_rdata, 32'h0);
        check("fm_ls", {ls_rvalid, ls_err}, 2'b00);

        // Tie after reset: fetch first, load in the fetch RESP, fetch again next tie
        do_reset();
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h40;
        #1;
        check("tie1_gnt", {if_gnt, ls_gnt}, 2'b10);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check("tie1_access_gnt", {if_gnt, ls_gnt}, 2'b00);
        check("tie1_mem_addr", mem_addr, 32'h100);
        @(negedge clk);
        #1;
        check("tie1_if_rvalid", if_rvalid, 1'b1);
        check("tie1_ls_gnt", {if_gnt, ls_gnt}, 2'b01);
        @(negedge clk);
        ls_req = 1'b0;
        #1;
        check("tie1_ls_addr", mem_addr, 32'h40);
        @(negedge clk);
        if_req = 1'b1; ls_req = 1'b1; ls_addr = 32'h48;
        #1;
        check("tie1_ls_rvalid", ls_rvalid, 1'b1);
        check("tie1_ls_rdata", ls_rdata, mem_model(32'h40));
        check("tie2_gnt", {if_gnt, ls_gnt}, 2'b10);
        @(negedge clk);
        if_req = 1'b0;
        @(negedge clk);
        #1;
        check("tie2_if_rvalid", if_rvalid, 1'b1);
        check("tie2_ls_gnt", ls_gnt, 1'b1);
        @(negedge clk);
        ls_req = 1'b0;
        @(negedge clk);
        #1;
        check("tie2_ls_rdata", ls_rdata, mem_model(32'h48));

        // Load-store legality and data table
        ls_txn(1'b0, 3'b010, 32'h0000_0040, 32'h0,          1'b0);
        ls_txn(1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF,  1'b0);
        ls_txn(1'b0, 3'b010, 32'h0000_0203, 32'h0,          1'b1);
        ls_txn(1'b0, 3'b001, 32'h0000_0201, 32'h0,          1'b1);
        ls_txn(1'b0, 3'b101, 32'h0000_0202, 32'h0,          1'b0);
        ls_txn(1'b0, 3'b100, 32'h0000_0203, 32'h0,          1'b0);
        ls_txn(1'b0, 3'b011, 32'h0000_0000, 32'h0,          1'b1);
        ls_txn(1'b0, 3'b110, 32'h0000_0000, 32'h0,          1'b1);
        ls_txn(1'b1, 3'b100, 32'h0000_0004, 32'h1234_5678,  1'b1);
        ls_txn(1'b1, 3'b010, 32'h0000_0006, 32'h1234_5678,  1'b1);
        ls_txn(1'b1, 3'b000, 32'h0000_0007, 32'hCAFE_F00D,  1'b0);

        // Reset asserted during ACCESS of a load
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h44;
        #1;
        check("ra_gnt", ls_gnt, 1'b1);
        @(negedge clk);
        ls_req = 1'b0;
        #1;
        check("ra_mem_re", mem_re, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ra_mem_re_drop", mem_re, 1'b0);
        check("ra_mem_addr_zero", mem_addr, 32'h0);
        @(negedge clk);
        #1;
        check("ra_no_rvalid", ls_rvalid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("ra_idle", {ls_rvalid, mem_re, mem_we}, 3'b000);
        ls_txn(1'b0, 3'b010, 32'h0000_0048, 32'h0, 1'b0);

        // Back-to-back loads held continuously
        gnts = 0; rvs = 0; last_g = 0; cyc = 0;
        ls_we = 1'b0; ls_funct3 = 3'b010;
        while ((gnts < 100 || rvs < gnts) && cyc < 600) begin
            @(negedge clk);
            cyc++;
            ls_req  = (gnts < 100);
            ls_addr = 32'h1000 + 32'(gnts) * 32'd4;
            #1;
            if (ls_rvalid) begin
                rvs++;
                if (exp_q.size() == 0) check("b2b_extra_rvalid", 1'b1, 1'b0);
                else check("b2b_rdata", ls_rdata, exp_q.pop_front());
            end
            if (ls_gnt) begin
                if (gnts > 0) check("b2b_gap", 64'(cyc - last_g), 64'd2);
                last_g = cyc;
                exp_q.push_back(mem_model(ls_addr));
                gnts++;
            end
        end
        ls_req = 1'b0;
        check("b2b_gnts", 64'(gnts), 64'd100);
        check("b2b_rvalids", 64'(rvs), 64'd100);
        check("b2b_pending", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
